repopulation: RTL and testbench

- Regenerates a full GA population from the survivors the selection stage emits, running the pipeline in the reverse direction: it takes sel_pop in and produces pop out.
- Elites (the N_SEL survivors) are copied unchanged. The remaining N_POP-N_SEL slots are filled one child per cycle by single-point crossover of two LFSR-chosen survivors.
- Output feeds the fitness/selection stage of the next generation; uses the same start/done handshake.

---
 rtl/repopulation_if.sv | 14 +
 rtl/repopulation.sv | 108 ++++++++++
 tb/tb_repopulation.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/repopulation_if.sv
// Handshake and data bundle between the selection stage and the repopulation block.
interface repopulation_if #(
  parameter int IND_W = 25,
  parameter int N_POP = 300,
  parameter int N_SEL = 60
);
  logic                     start;
  logic [N_SEL*IND_W-1:0]   sel_pop;
  logic [N_POP*IND_W-1:0]   pop;
  logic                     done;

  modport master (output start, output sel_pop, input pop, input done);
  modport slave  (input start, input sel_pop, output pop, output done);
endinterface

// File: rtl/repopulation.sv
// Rebuilds an N_POP population from N_SEL survivors: elites copied, the rest bred by LFSR crossover.
// Optional per-child single-bit mutation is enabled by defining MUTATION_EN.
module repopulation #(
  parameter int          IND_W    = 25,
  parameter int          N_POP    = 300,
  parameter int          N_SEL    = 60,
  parameter logic [31:0] SEED     = 32'hACE12025,
  parameter int          MUT_RATE = 8
) (
  input  logic            clk,
  input  logic            rst,
  repopulation_if.slave   bus
);

  localparam int          SLOT_W = $clog2(N_POP);
  localparam int          IDX_W  = (N_SEL > 1) ? $clog2(N_SEL) : 1;
  localparam int          BIT_W  = (IND_W > 1) ? $clog2(IND_W) : 1;
  localparam logic [31:0] TAPS   = 32'h80200003;

  if (SEED == 32'd0 || MUT_RATE < 0 || MUT_RATE > 256) begin : g_param_chk
    $error("repopulation: SEED must be nonzero and MUT_RATE within 0..256");
  end

  typedef enum logic [1:0] {IDLE, BREED, DONE} state_t;

  state_t                  state;
  logic [SLOT_W-1:0]       slot;
  logic [31:0]             lfsr;
  logic [N_SEL*IND_W-1:0]  sel_q;
  logic [N_POP*IND_W-1:0]  pop_q;
  logic                    done_q;

  logic [IDX_W-1:0]        idx_a;
  logic [IDX_W-1:0]        idx_b;
  logic [BIT_W-1:0]        cut;
  logic [IND_W-1:0]        par_a;
  logic [IND_W-1:0]        par_b;
  logic [IND_W-1:0]        cut_mask;
  logic [IND_W-1:0]        child;

  function automatic logic [31:0] scale16(input logic [15:0] field, input int n);
    scale16 = ({16'd0, field} * 32'(n)) >> 16;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    lfsr_next = cur[0] ? ((cur >> 1) ^ TAPS) : (cur >> 1);
  endfunction

  // Multiply-high scaling keeps parent indices and cut point in range without modulo.
  assign idx_a = IDX_W'(scale16(lfsr[15:0],  N_SEL));
  assign idx_b = IDX_W'(scale16(lfsr[31:16], N_SEL));
  assign cut   = BIT_W'(scale16(lfsr[23:8],  IND_W));

  always_comb begin
    par_a    = sel_q[idx_a*IND_W +: IND_W];
    par_b    = sel_q[idx_b*IND_W +: IND_W];
    cut_mask = (IND_W'(1) << cut) - IND_W'(1);
    child    = (par_a & cut_mask) | (par_b & ~cut_mask);
`ifdef MUTATION_EN
    if ({24'd0, lfsr[7:0]} < 32'(MUT_RATE))
      child = child ^ (IND_W'(1) << BIT_W'(scale16(lfsr[27:12], IND_W)));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pop_q  <= '0;
      done_q <= 1'b0;
      slot   <= '0;
      lfsr   <= SEED;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sel_q                    <= bus.sel_pop;
            pop_q[N_SEL*IND_W-1:0]   <= bus.sel_pop;
            slot                     <= SLOT_W'(N_SEL);
            state                    <= BREED;
          end
        end
        BREED: begin
          pop_q[slot*IND_W +: IND_W] <= child;
          lfsr                       <= lfsr_next(lfsr);
          if (slot == SLOT_W'(N_POP - 1)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            slot <= slot + SLOT_W'(1);
          end
        end
        DONE: begin
          // A held start keeps the result parked; dropping it rearms IDLE.
          if (!bus.start) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pop  = pop_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_repopulation.sv
// Directed bench for repopulation with a bench-side LFSR/crossover reference model.
module tb_repopulation;

  localparam int          IND_W = 25;
  localparam int          N_POP = 300;
  localparam int          N_SEL = 60;
  localparam int          SELW  = N_SEL*IND_W;
  localparam int          POPW  = N_POP*IND_W;
  localparam int          N_CH  = N_POP - N_SEL;
  localparam logic [31:0] SEED  = 32'hACE12025;
  localparam logic [31:0] TAPS  = 32'h80200003;
`ifdef MUTATION_EN
  localparam int          MUT_R = 256;
`else
  localparam int          MUT_R = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  repopulation_if #(.IND_W(IND_W), .N_POP(N_POP), .N_SEL(N_SEL)) bif ();

  repopulation #(
    .IND_W(IND_W), .N_POP(N_POP), .N_SEL(N_SEL), .SEED(SEED), .MUT_RATE(MUT_R)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  int            n_checks = 0;
  int            n_errors = 0;
  logic [31:0]   m_lfsr;
  logic [POPW-1:0] exp_pop;
  logic [POPW-1:0] fresh_pop;
  logic [POPW-1:0] run1_pop;
  logic [SELW-1:0] sel_idx;
  logic [SELW-1:0] sel_ones;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input string tag);
    for (int s = 0; s < N_POP; s++)
      check($sformatf("%s.slot%0d", tag, s),
            32'(bif.pop[s*IND_W +: IND_W]), 32'(exp_pop[s*IND_W +: IND_W]));
  endtask

  // Reference: elites verbatim, then one child per LFSR state, bit by bit.
  task automatic model_run(input logic [SELW-1:0] sel);
    int unsigned ia, ib, cut, mpos;
    logic [IND_W-1:0] a, b, c;
    exp_pop[SELW-1:0] = sel;
    for (int s = N_SEL; s < N_POP; s++) begin
      ia   = (32'(m_lfsr[15:0])  * 32'(N_SEL)) >> 16;
      ib   = (32'(m_lfsr[31:16]) * 32'(N_SEL)) >> 16;
      cut  = (32'(m_lfsr[23:8])  * 32'(IND_W)) >> 16;
      mpos = (32'(m_lfsr[27:12]) * 32'(IND_W)) >> 16;
      a = sel[ia*IND_W +: IND_W];
      b = sel[ib*IND_W +: IND_W];
      for (int i = 0; i < IND_W; i++)
        c[i] = (i < int'(cut)) ? a[i] : b[i];
`ifdef MUTATION_EN
      if (int'(m_lfsr[7:0]) < MUT_R) c[mpos] = ~c[mpos];
`else
      if (mpos > 32'd1000) c = '0;
`endif
      exp_pop[s*IND_W +: IND_W] = c;
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ TAPS) : (m_lfsr >> 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bif.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = SEED;
  endtask

  // Launch a run; hold>0 keeps start high for that many edges from E0.
  task automatic run_and_check(input string tag, input logic [SELW-1:0] sel,
                               input int hold, input bit toggle);
    int  edges;
    bit  seen;
    int  drops;
    @(negedge clk);
    bif.sel_pop = sel;
    bif.start   = 1'b1;
    @(negedge clk);
    model_run(sel);
    if (hold == 0) bif.start = 1'b0;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 400) begin
      if (toggle) bif.sel_pop = edges[0] ? sel_ones : '0;
      @(negedge clk);
      edges++;
      seen = bif.done;
    end
    check({tag, ".latency"}, 32'(edges), 32'(N_CH));
    check_pop(tag);
    if (hold > 0) begin
      drops = 0;
      repeat (hold - 1 - N_CH) begin
        @(negedge clk);
        if (!bif.done) drops++;
      end
      check({tag, ".done_held"}, 32'(drops), 32'd0);
      bif.start = 1'b0;
      check({tag, ".done_before_fall"}, 32'(bif.done), 32'd1);
      @(negedge clk);
      check({tag, ".done_after_fall"}, 32'(bif.done), 32'd0);
      repeat (3) @(negedge clk);
      check({tag, ".no_rerun"}, 32'(bif.done), 32'd0);
    end else begin
      @(negedge clk);
      check({tag, ".done_clear"}, 32'(bif.done), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nz;
    bif.start   = 1'b0;
    bif.sel_pop = '0;
    sel_ones    = '1;
    for (int k = 0; k < N_SEL; k++) sel_idx[k*IND_W +: IND_W] = IND_W'(k);

    do_reset();
    check("rst.done", 32'(bif.done), 32'd0);
    check("rst.pop_ones", 32'($countones(bif.pop)), 32'd0);

    run_and_check("idx", sel_idx, 0, 1'b0);
    check("idx.elites", 32'(bif.pop[SELW-1:0] == sel_idx), 32'd1);
`ifndef MUTATION_EN
    nz = 0;
    for (int s = N_SEL; s < N_POP; s++)
      if (bif.pop[s*IND_W+6 +: IND_W-6] != '0) nz++;
    check("idx.child_high_bits", 32'(nz), 32'd0);
`endif
    fresh_pop = bif.pop;

    run_and_check("ones", sel_ones, 0, 1'b0);
`ifndef MUTATION_EN
    check("ones.count", 32'($countones(bif.pop)), 32'(POPW));
`endif

    run_and_check("zeros", '0, 0, 1'b0);
`ifdef MUTATION_EN
    nz = 0;
    for (int s = N_SEL; s < N_POP; s++)
      if ($countones(bif.pop[s*IND_W +: IND_W]) != 1) nz++;
    check("mut.one_hot_children", 32'(nz), 32'd0);
    check("mut.elites_zero", 32'($countones(bif.pop[SELW-1:0])), 32'd0);
`else
    check("zeros.count", 32'($countones(bif.pop)), 32'd0);
`endif

    // Abort a run partway through breeding.
    @(negedge clk);
    bif.sel_pop = sel_idx;
    bif.start   = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst.done", 32'(bif.done), 32'd0);
    check("midrst.pop_ones", 32'($countones(bif.pop)), 32'd0);
    rst = 1'b0;
    m_lfsr = SEED;

    run_and_check("rerun", sel_idx, 0, 1'b0);
    check("rerun.same_as_fresh", 32'(bif.pop == fresh_pop), 32'd1);
    run1_pop = bif.pop;
    run_and_check("second", sel_idx, 0, 1'b0);
    check("second.differs", 32'(bif.pop != run1_pop), 32'd1);

    run_and_check("hold", sel_idx, 300, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
